serial_deserializer: RTL and testbench
======================================

# serial_deserializer

Receive-side partner of the loadable down-counter/shift block. It samples a serial bit stream on `serin` under a bit-enable strobe and assembles WIDTH-bit words MSB-first. Each completed word is presented on a parallel output with a valid/acknowledge handshake. It sits directly downstream of the counter's `serout` and rebuilds the byte that was loaded into the counter, so the pair closes the serial loop.

## Interface
- `WIDTH`, default 8: word length in bits; legal range 2..16.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: bit strobe; `serin`/`start` are sampled only on edges where `en`=1.
- `serin`  in  1: serial data, MSB first.
- `start`  in  1: frame marker, qualified by `en`; marks the bit sampled that edge as bit WIDTH-1 (MSB) of a new word.
- `ack`  in  1: consumer acknowledge for `dout`.
- `dout`  out  WIDTH: last completed word.
- `dvalid`  out  1: `dout` holds an unacknowledged word.
- `busy`  out  1: a word is partially received.
- `ovf`  out  1: sticky; a completed word overwrote an unacknowledged one.
- `sync_err`  out  1: one-cycle pulse; `start` arrived mid-word.

## Operation
- Reset values: `dout`=0, `dvalid`=0, `busy`=0, `ovf`=0, `sync_err`=0, shift register=0, bit counter=0, state IDLE.
- FSM states: IDLE, SHIFT.
- IDLE:
  - `en`&`start`: shift in `serin`, load remaining-bit counter with WIDTH-1, go to SHIFT.
  - `en` without `start`: bit discarded, stay IDLE.
- SHIFT, on `en`&!`start`:
  - shift register takes {sreg[WIDTH-2:0], `serin`}; counter decrements.
  - When the counter is 1 on that edge (the last bit), `dout` is loaded with {sreg[WIDTH-2:0], `serin`}, `dvalid` is set, and the state goes to IDLE.
- SHIFT, on `en`&`start` (resync):
  - Partial word discarded.
  - This bit becomes the new MSB; counter reloads to WIDTH-1; stay in SHIFT.
  - `sync_err` pulses high for one cycle.
- `en`=0: shift register, counter and state hold. `start` is ignored.
- Handshake:
  - `dvalid` stays high until an edge with `ack`=1, which clears it.
  - `ack` while `dvalid`=0 has no effect.
- Simultaneous events:
  - Completion with `dvalid`=1 and `ack`=0: `dout` is overwritten, `dvalid` stays 1, `ovf` is set.
  - Completion with `ack`=1 on the same edge: the new word loads, `dvalid` stays 1, no `ovf`.
- `ovf` clears only on `rst`.
- `busy` = (state == SHIFT).
- Reset mid-word: partial data lost, all outputs return to their reset values immediately (asynchronous).

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Latency: `dvalid` and the new `dout` are visible after the edge that samples the LSB. Minimum word time is WIDTH consecutive `en` cycles.
- Back-to-back words are supported: a new `start` may coincide with the edge after completion.
- `sync_err` is high for exactly the one cycle following the resync edge.
- `en` may be held high continuously, or gated (e.g. one pulse per bit period).

## Structure
- The shared package/include holds:
  - state encodings as localparams: IDLE=1'b0, SHIFT=1'b1;
  - `WIDTH` default;
  - the bit-counter width constant clog2(WIDTH)+1.
- One natural sub-module, `shift_in_reg`: a WIDTH-bit serial-in/parallel-out register with a shift-enable and asynchronous active-high `rst`.
- The FSM, bit counter and handshake/overflow logic stay in the top.

## Test plan
- Reset, then `start`+`en` with bits 1,0,1,1,0,0,0,0 on consecutive edges -> `dout`=8'hB0, `dvalid`=1 after the 8th edge, `busy` low; `ack` for one cycle -> `dvalid`=0.
- Same word with `en` pulsed every other cycle (bits only on `en`=1) -> `dout`=8'hB0 after 8 strobes; no change on idle edges.
- Receive 8'h0B and leave it unacknowledged, then receive 8'hA5 -> `dout`=8'hA5, `dvalid`=1, `ovf`=1 and it stays set; repeat with `ack` on the completion edge -> `ovf` stays 0.
- Send 4 bits, then `start` again followed by 8'h3C -> `sync_err` one-cycle pulse, `dout`=8'h3C, no stray bits from the partial word.
- Assert `rst` after 5 bits of a word -> `busy`=0, `dout`=0, `dvalid`=0 immediately; next full frame 8'hFF is received correctly.
- Stream bits with `en`=1 but no `start` -> stays IDLE, `dvalid` never rises.

Source files
------------

// File: rtl/serial_deserializer_pkg.sv
// Shared constants for the serial deserializer: state encodings, default width,
// and the bit-counter width helper.
package serial_deserializer_pkg;

  localparam logic IDLE_ENC  = 1'b0;
  localparam logic SHIFT_ENC = 1'b1;

  typedef enum logic {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC
  } state_t;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_deserializer_shift_in_reg.sv
// Serial-in / parallel-out register, MSB-first: each enabled edge shifts din into bit 0.
module shift_in_reg
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Rebuilds WIDTH-bit words from an en-qualified serial stream framed by start,
// and hands them out over a dvalid/ack handshake.
//
// state | meaning
// IDLE  | waiting for an en-qualified start; other bits are dropped
// SHIFT | word in progress; cnt holds bits still to be received
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serin,
  input  logic             start,
  input  logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             busy,
  output logic             ovf,
  output logic             sync_err
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word;
  logic             shift_en;

  // A start always shifts (it is the new MSB); plain bits only shift mid-word.
  assign shift_en = en & ((state == SHIFT) | start);
  assign word     = {sreg[WIDTH-2:0], serin};
  assign busy     = (state == SHIFT);

  shift_in_reg #(.WIDTH(WIDTH)) u_shift_in_reg (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (serin),
    .q        (sreg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dout     <= '0;
      dvalid   <= 1'b0;
      ovf      <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      // A completing word below takes priority over this clear.
      if (ack) dvalid <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              cnt   <= CW'(WIDTH - 1);
              state <= SHIFT;
            end
          end
          SHIFT: begin
            if (start) begin
              cnt      <= CW'(WIDTH - 1);
              sync_err <= 1'b1;
            end else if (cnt == CW'(1)) begin
              cnt    <= '0;
              state  <= IDLE;
              dout   <= word;
              dvalid <= 1'b1;
              if (dvalid && !ack) ovf <= 1'b1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (WIDTH=8) with immediate-assertion checks.
module tb_serial_deserializer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       serin;
  logic       start;
  logic       ack;
  logic [7:0] dout;
  logic       dvalid;
  logic       busy;
  logic       ovf;
  logic       sync_err;

  int n_cmp = 0;
  int n_err = 0;

  serial_deserializer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .serin    (serin),
    .start    (start),
    .ack      (ack),
    .dout     (dout),
    .dvalid   (dvalid),
    .busy     (busy),
    .ovf      (ovf),
    .sync_err (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    en    = 1'b1;
    serin = b;
    start = st;
    tick();
    en    = 1'b0;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit ack_last);
    for (int i = 7; i >= 0; i--) begin
      en    = 1'b1;
      serin = w[i];
      start = (i == 7);
      ack   = ack_last && (i == 0);
      tick();
    end
    en    = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; en = 1'b0; serin = 1'b0; start = 1'b0; ack = 1'b0;
    tick(); tick();
    check("rst_dout", 16'(dout), 16'h00);
    check("rst_dvalid", 16'(dvalid), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_ovf", 16'(ovf), 16'h0);
    check("rst_sync_err", 16'(sync_err), 16'h0);
    rst = 1'b0;
    tick();

    // Continuous en: 1,0,1,1,0,0,0,0 -> B0
    w = 8'hB0;
    send_bit(w[7], 1'b1);
    check("b0_busy_after_msb", 16'(busy), 16'h1);
    for (int i = 6; i >= 1; i--) send_bit(w[i], 1'b0);
    check("b0_dvalid_before_lsb", 16'(dvalid), 16'h0);
    send_bit(w[0], 1'b0);
    check("b0_dout", 16'(dout), 16'hB0);
    check("b0_dvalid", 16'(dvalid), 16'h1);
    check("b0_busy_done", 16'(busy), 16'h0);
    do_ack();
    check("b0_ack_clears", 16'(dvalid), 16'h0);
    do_ack();
    check("ack_idle_noeffect", 16'(dvalid), 16'h0);

    // Gated en: one strobe every other cycle
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], i == 7);
      tick();
      if (i == 4) begin
        check("gated_busy_mid", 16'(busy), 16'h1);
        check("gated_dvalid_mid", 16'(dvalid), 16'h0);
      end
    end
    check("gated_dout", 16'(dout), 16'hB0);
    check("gated_dvalid", 16'(dvalid), 16'h1);
    start = 1'b1; tick(); tick(); start = 1'b0;
    check("gated_start_no_en_busy", 16'(busy), 16'h0);
    check("gated_hold_dvalid", 16'(dvalid), 16'h1);
    do_ack();

    // Overflow: 0B unacked, then A5 back-to-back
    send_word(8'h0B, 1'b0);
    check("ovf_first_dout", 16'(dout), 16'h0B);
    check("ovf_first_ovf", 16'(ovf), 16'h0);
    send_word(8'hA5, 1'b0);
    check("ovf_dout", 16'(dout), 16'hA5);
    check("ovf_dvalid", 16'(dvalid), 16'h1);
    check("ovf_set", 16'(ovf), 16'h1);
    do_ack();
    tick();
    check("ovf_sticky", 16'(ovf), 16'h1);
    check("ovf_ack_dvalid", 16'(dvalid), 16'h0);

    // Ack on completion edge: no overflow
    rst = 1'b1; #2; rst = 1'b0;
    check("ovf_cleared_by_rst", 16'(ovf), 16'h0);
    tick();
    send_word(8'h0B, 1'b0);
    send_word(8'hA5, 1'b1);
    check("ackc_dout", 16'(dout), 16'hA5);
    check("ackc_dvalid", 16'(dvalid), 16'h1);
    check("ackc_ovf", 16'(ovf), 16'h0);
    do_ack();

    // Resync: 4 bits of ones, then start with 3C
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    check("resync_no_err_yet", 16'(sync_err), 16'h0);
    w = 8'h3C;
    send_bit(w[7], 1'b1);
    check("resync_err_pulse", 16'(sync_err), 16'h1);
    check("resync_busy", 16'(busy), 16'h1);
    send_bit(w[6], 1'b0);
    check("resync_err_one_cycle", 16'(sync_err), 16'h0);
    for (int i = 5; i >= 0; i--) send_bit(w[i], 1'b0);
    check("resync_dout", 16'(dout), 16'h3C);
    check("resync_dvalid", 16'(dvalid), 16'h1);
    check("resync_ovf", 16'(ovf), 16'h0);

    // Reset after 5 bits, leaving 3C unacked so dout/dvalid are nonzero
    w = 8'h96;
    send_bit(w[7], 1'b1);
    for (int i = 6; i >= 3; i--) send_bit(w[i], 1'b0);
    check("midrst_busy_before", 16'(busy), 16'h1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 16'(busy), 16'h0);
    check("midrst_dout", 16'(dout), 16'h00);
    check("midrst_dvalid", 16'(dvalid), 16'h0);
    #1;
    rst = 1'b0;
    tick();
    send_word(8'hFF, 1'b0);
    check("after_rst_dout", 16'(dout), 16'hFF);
    check("after_rst_dvalid", 16'(dvalid), 16'h1);
    do_ack();

    // Bits without start are dropped
    for (int i = 0; i < 12; i++) send_bit(1'(i % 2), 1'b0);
    check("nostart_busy", 16'(busy), 16'h0);
    check("nostart_dvalid", 16'(dvalid), 16'h0);
    check("nostart_dout", 16'(dout), 16'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
